label_resolver: RTL and testbench

LABEL_RESOLVER -- requirements
Module: label_resolver

---
 rtl/label_resolver_if.sv | 26 ++
 rtl/label_resolver.sv | 110 +++++++++++
 tb/tb_label_resolver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/label_resolver_if.sv
// rtl/label_resolver_if.sv - label table RAM port bundle between resolver and RAM
interface label_resolver_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] ram_r_addr;
    logic [WIDTH-1:0] ram_rdata;
    logic             ram_wen;
    logic [WIDTH-1:0] ram_w_addr;
    logic [WIDTH-1:0] ram_wdata;

    modport master (
        output ram_r_addr,
        input  ram_rdata,
        output ram_wen,
        output ram_w_addr,
        output ram_wdata
    );

    modport slave (
        input  ram_r_addr,
        output ram_rdata,
        input  ram_wen,
        input  ram_w_addr,
        input  ram_wdata
    );
endinterface

// File: rtl/label_resolver.sv
// rtl/label_resolver.sv - single-pass flattening of a union-find label equivalence table
module label_resolver #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] num_labels,
    label_resolver_if.master ram,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] root_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SELF,
        S_PARENT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] root_count_q, root_count_d;
    logic             error_q, error_d;
    logic             last;

    assign last       = (i_q == n_q);
    assign root_count = root_count_q;
    assign error      = error_q;

    always_comb begin
        state_d        = state_q;
        i_d            = i_q;
        n_d            = n_q;
        root_count_d   = root_count_q;
        error_d        = error_q;
        busy           = 1'b0;
        done           = 1'b0;
        ram.ram_r_addr = '0;
        ram.ram_wen    = 1'b0;
        ram.ram_w_addr = '0;
        ram.ram_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    root_count_d = '0;
                    error_d      = 1'b0;
                    n_d          = num_labels;
                    i_d          = WIDTH'(1);
                    state_d      = (num_labels == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy           = 1'b1;
                ram.ram_r_addr = i_q;
                state_d        = S_SELF;
            end
            S_SELF: begin
                busy = 1'b1;
                if (ram.ram_rdata == i_q) begin
                    root_count_d = root_count_q + WIDTH'(1);
                    state_d      = last ? S_DONE : S_ISSUE;
                    i_d          = last ? i_q : i_q + WIDTH'(1);
                end else if ((ram.ram_rdata != '0) && (ram.ram_rdata < i_q)) begin
                    // Parent is lower-numbered, so its entry is already flattened to its root.
                    ram.ram_r_addr = ram.ram_rdata;
                    state_d        = S_PARENT;
                end else begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_PARENT: begin
                busy           = 1'b1;
                ram.ram_wen    = 1'b1;
                ram.ram_w_addr = i_q;
                ram.ram_wdata  = ram.ram_rdata;
                state_d        = last ? S_DONE : S_ISSUE;
                i_d            = last ? i_q : i_q + WIDTH'(1);
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            n_q          <= '0;
            root_count_q <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            n_q          <= n_d;
            root_count_q <= root_count_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_label_resolver.sv
// tb/tb_label_resolver.sv - scoreboard bench for label_resolver with a registered-read RAM model
module tb_label_resolver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num_labels = '0;
    logic        busy, done, error;
    logic [31:0] root_count;

    label_resolver_if #(.WIDTH(32)) rif ();

    label_resolver #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_labels (num_labels),
        .ram        (rif),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .root_count (root_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:15];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    always @(posedge clk) begin
        rif.ram_rdata <= mem[rif.ram_r_addr[3:0]];
        if (rif.ram_wen) mem[rif.ram_w_addr[3:0]] <= rif.ram_wdata;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    int          model_tab [0:15];
    int          exp_root, exp_err, exp_cyc;

    always @(negedge clk) begin
        if (reset && rif.ram_wen) begin
            check("wr_expected", (wq_a.size() != 0), 1);
            if (wq_a.size() != 0) begin
                check("wr_addr", rif.ram_w_addr, wq_a.pop_front());
                check("wr_data", rif.ram_wdata, wq_d.pop_front());
            end
        end
    end

    task automatic model(input int n);
        exp_root = 0;
        exp_err  = 0;
        exp_cyc  = 0;
        for (int i = 1; i <= n; i++) begin
            int p;
            p = model_tab[i];
            if (p == i) begin
                exp_root++;
                exp_cyc += 2;
            end else if (p > 0 && p < i) begin
                model_tab[i] = model_tab[p];
                wq_a.push_back(i);
                wq_d.push_back(model_tab[i]);
                exp_cyc += 3;
            end else begin
                exp_err = 1;
                exp_cyc += 2;
                break;
            end
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 4'(i);
            ld_data = 32'(model_tab[i]);
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_wen"}, rif.ram_wen, 0);
        check({tag, "_raddr"}, rif.ram_r_addr, 0);
        check({tag, "_waddr"}, rif.ram_w_addr, 0);
        check({tag, "_wdata"}, rif.ram_wdata, 0);
        check({tag, "_roots"}, root_count, 0);
    endtask

    task automatic run_pass(input int n, input bit poke);
        int cyc;
        model(n);
        @(negedge clk);
        start      = 1'b1;
        num_labels = 32'(n);
        @(negedge clk);
        start = 1'b0;
        if (n > 0) check("busy_after_start", busy, 1);
        cyc = 0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (poke && cyc == 3);
        end
        start = 1'b0;
        check("done_seen", done, 1);
        check("latency", cyc, exp_cyc);
        check("busy_at_done", busy, 0);
        check("root_count", root_count, exp_root);
        check("error", error, exp_err);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_single", done, 0);
        check("idle_after_done", busy, 0);
        @(negedge clk);
        check("still_idle", busy, 0);
        check("root_count_held", root_count, exp_root);
        check("writes_drained", wq_a.size(), 0);
        for (int i = 1; i <= n; i++) check($sformatf("table[%0d]", i), mem[i], model_tab[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        for (int i = 0; i < 16; i++) model_tab[i] = i;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Worked example: mixed roots and two-level chains
        model_tab[1] = 1; model_tab[2] = 1; model_tab[3] = 2; model_tab[4] = 4; model_tab[5] = 3;
        load_mem();
        run_pass(5, 0);

        // Empty table goes straight to DONE
        run_pass(0, 0);

        // Forward-pointing parent is an invariant violation
        model_tab[1] = 1; model_tab[2] = 3;
        load_mem();
        run_pass(2, 0);

        // Starts during the pass and in the DONE cycle are ignored
        for (int i = 1; i <= 4; i++) model_tab[i] = i;
        load_mem();
        run_pass(4, 1);

        // Long chain collapses onto label 1
        model_tab[1] = 1;
        for (int i = 2; i <= 8; i++) model_tab[i] = i - 1;
        load_mem();
        run_pass(8, 0);

        // Random valid forests
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 12; i++) model_tab[i] = $urandom_range(i, 1);
            load_mem();
            run_pass(12, 0);
        end

        // Asynchronous reset in the PARENT cycle of label 3
        model_tab[1] = 1; model_tab[2] = 1; model_tab[3] = 2; model_tab[4] = 4; model_tab[5] = 3;
        load_mem();
        model(5);
        @(negedge clk);
        start      = 1'b1;
        num_labels = 32'd5;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (rif.ram_wen && rif.ram_w_addr == 32'd3) found = 1;
            else @(negedge clk);
        end
        check("abort_point_reached", found, 1);
        #1 reset = 1'b0;
        #1 check_outputs_zero("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_no_write3", mem[3], 2);
        check("abort_kept_write2", mem[2], 1);
        check("abort_no_done", done, 0);
        wq_a.delete();
        wq_d.delete();
        reset = 1'b1;
        model_tab[1] = 1; model_tab[2] = 1; model_tab[3] = 2; model_tab[4] = 4; model_tab[5] = 3;
        run_pass(5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
